// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_byte
//  Brief    : 8N1 UART receiver with 2-flop input synchronizer, clocks-per-bit
//             divider and 3-sample mid-bit majority vote. Delivers a parallel
//             byte with a one-cycle strobe, plus framing-error and busy flags.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_byte #(
  parameter int BAUD_DIV = 434,  // clk cycles per serial bit (8..65535)
  parameter int CNT_W    = 16    // width of the bit-period counter
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rout,
  output logic       rout_en,
  output logic       frame_err,
  output logic       rx_busy
);

  // Mid-bit sample points: two captures, then the vote one cycle later.
  localparam int               c_HALF     = BAUD_DIV / 2;
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] c_CNT_S0   = CNT_W'(c_HALF - 1);
  localparam logic [CNT_W-1:0] c_CNT_S1   = CNT_W'(c_HALF);
  localparam logic [CNT_W-1:0] c_CNT_VOTE = CNT_W'(c_HALF + 1);

  typedef enum logic [2:0] {
    S_WAITHI = 3'd0,
    S_IDLE   = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_rxs;
  logic [1:0]       r_prime;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic             r_s0;
  logic             r_s1;
  logic [7:0]       r_shreg;

  logic             w_vote;
  logic             w_at_vote;
  logic             w_at_last;

  // Majority of the two early captures and the live synchronized sample.
  assign w_vote    = (r_s0 & r_s1) | (r_s0 & r_rxs) | (r_s1 & r_rxs);
  assign w_at_vote = (r_cnt == c_CNT_VOTE);
  assign w_at_last = (r_cnt == c_CNT_LAST);

  // Two-flop synchronizer for the asynchronous serial pin; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rxs   <= r_sync1;
    end
  end

  // Marks when r_rxs holds a real pin sample rather than its reset value,
  // so a line still held low after reset is not mistaken for idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prime <= 2'b00;
    end else begin
      r_prime <= {r_prime[0], 1'b1};
    end
  end

  // Capture the two early mid-bit samples feeding the majority vote.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else begin
      if (r_cnt == c_CNT_S0) r_s0 <= r_rxs;
      if (r_cnt == c_CNT_S1) r_s1 <= r_rxs;
    end
  end

  // Receive state machine with registered byte, strobes and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_WAITHI;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shreg   <= 8'h00;
      rout      <= 8'h00;
      rout_en   <= 1'b0;
      frame_err <= 1'b0;
      rx_busy   <= 1'b1;
    end else begin
      rout_en   <= 1'b0;
      frame_err <= 1'b0;
      case (r_state)
        S_WAITHI: begin
          if (r_prime[1] && r_rxs) begin
            r_state <= S_IDLE;
            rx_busy <= 1'b0;
          end
        end
        S_IDLE: begin
          if (!r_rxs) begin
            r_state <= S_START;
            r_cnt   <= '0;
            rx_busy <= 1'b1;
          end
        end
        S_START: begin
          if (w_at_vote && w_vote) begin
            // Start bit did not hold low to mid-bit: treat as line noise.
            r_state <= S_IDLE;
            rx_busy <= 1'b0;
          end else if (w_at_last) begin
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_state   <= S_DATA;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_at_vote) begin
            r_shreg <= {w_vote, r_shreg[7:1]};
          end
          if (w_at_last) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (w_at_vote) begin
            if (w_vote) begin
              // Return at mid-stop-bit to tolerate back-to-back frames.
              rout    <= r_shreg;
              rout_en <= 1'b1;
              r_state <= S_IDLE;
              rx_busy <= 1'b0;
            end else begin
              // Stop bit low: break or misframe, wait for line to go high.
              frame_err <= 1'b1;
              r_state   <= S_WAITHI;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= S_WAITHI;
          rx_busy <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_byte.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_byte
//  Brief    : Directed self-checking bench for uart_rx_byte (BAUD_DIV=16).
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_byte;

  localparam int BAUD_DIV = 16;
  localparam int CNT_W    = 16;
  localparam int FRAME    = 10 * BAUD_DIV;
  // Negedge count from driving the start bit to seeing rout_en:
  // 3 edges to enter START, then 9*BAUD_DIV + HALF + 2 edges.
  localparam int LAT      = 3 + 9 * BAUD_DIV + BAUD_DIV / 2 + 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] rout;
  logic       rout_en;
  logic       frame_err;
  logic       rx_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int         n_en  = 0;
  int         n_err = 0;
  int         en_cyc[$];
  logic [7:0] en_dat[$];
  int         err_cyc[$];
  logic       prev_en  = 1'b0;
  logic       prev_err = 1'b0;

  uart_rx_byte #(
    .BAUD_DIV (BAUD_DIV),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .rout      (rout),
    .rout_en   (rout_en),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int en_cyc_at(input int i);
    return (i < en_cyc.size()) ? en_cyc[i] : -1;
  endfunction

  function automatic logic [7:0] en_dat_at(input int i);
    return (i < en_dat.size()) ? en_dat[i] : 8'hxx;
  endfunction

  function automatic int err_cyc_at(input int i);
    return (i < err_cyc.size()) ? err_cyc[i] : -1;
  endfunction

  // Strobe monitor: logs pulses and checks width and exclusivity.
  always @(negedge clk) begin
    if (rout_en) begin
      n_en++;
      en_cyc.push_back(cyc);
      en_dat.push_back(rout);
      check("rout_en_width", {31'd0, prev_en}, 32'd0);
      check("en_and_err", {31'd0, frame_err}, 32'd0);
    end
    if (frame_err) begin
      n_err++;
      err_cyc.push_back(cyc);
      check("frame_err_width", {31'd0, prev_err}, 32'd0);
    end
    prev_en  = rout_en;
    prev_err = frame_err;
  end

  // Drives one 10-bit frame, one pin value per negedge. glitch_k inverts
  // the pin for that one sample; rst_k pulses rst_n low for 3 cycles.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input int glitch_k, input int rst_k, output int s);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    s = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (k == 0) s = cyc;
      if (rst_k >= 0 && k == rst_k)     rst_n = 1'b0;
      if (rst_k >= 0 && k == rst_k + 3) rst_n = 1'b1;
      rx = bits[k / BAUD_DIV] ^ (k == glitch_k);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  // Hard time bound in case the DUT wedges the run.
  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Directed stimulus sequence.
  initial begin
    int s, s1, s2, b, be;
    logic busy_a, busy_b, busy_c;

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rout", {24'd0, rout}, 32'h00);
    check("reset_rout_en", {31'd0, rout_en}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_rx_busy", {31'd0, rx_busy}, 32'd1);
    rst_n = 1'b1;
    idle(10);
    check("idle_busy", {31'd0, rx_busy}, 32'd0);

    // Single clean frame.
    b = n_en; be = n_err;
    send_frame(8'h67, 1'b1, -1, -1, s);
    idle(5);
    check("g_count", n_en - b, 32'd1);
    check("g_latency", en_cyc_at(b), s + LAT);
    check("g_data", {24'd0, en_dat_at(b)}, 32'h67);
    check("g_rout_hold", {24'd0, rout}, 32'h67);
    check("g_no_err", n_err - be, 32'd0);

    // Back-to-back frames with no idle between them.
    b = n_en;
    send_frame(8'h72, 1'b1, -1, -1, s1);
    send_frame(8'h30, 1'b1, -1, -1, s2);
    idle(5);
    check("b2b_count", n_en - b, 32'd2);
    check("b2b_data0", {24'd0, en_dat_at(b)}, 32'h72);
    check("b2b_data1", {24'd0, en_dat_at(b + 1)}, 32'h30);
    check("b2b_latency0", en_cyc_at(b), s1 + LAT);
    check("b2b_spacing", en_cyc_at(b + 1) - en_cyc_at(b), FRAME);

    // Short low pulse: false start only.
    b = n_en; be = n_err;
    busy_a = 1'b0; busy_b = 1'b1;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      rx = (k < 4) ? 1'b0 : 1'b1;
      if (k == 3)  busy_a = rx_busy;
      if (k == 16) busy_b = rx_busy;
    end
    check("glitch_busy_rise", {31'd0, busy_a}, 32'd1);
    check("glitch_busy_fall", {31'd0, busy_b}, 32'd0);
    check("glitch_no_en", n_en - b, 32'd0);
    check("glitch_no_err", n_err - be, 32'd0);
    check("glitch_rout", {24'd0, rout}, 32'h30);

    // Stop bit low followed by a held-low line.
    b = n_en; be = n_err;
    send_frame(8'h03, 1'b0, -1, -1, s);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    check("brk_busy_low_line", {31'd0, rx_busy}, 32'd1);
    @(negedge clk); rx = 1'b1;
    @(negedge clk); busy_a = rx_busy;
    @(negedge clk); busy_b = rx_busy;
    @(negedge clk); busy_c = rx_busy;
    check("brk_busy_n1", {31'd0, busy_a}, 32'd1);
    check("brk_busy_n2", {31'd0, busy_b}, 32'd1);
    check("brk_busy_n3", {31'd0, busy_c}, 32'd0);
    check("brk_err_count", n_err - be, 32'd1);
    check("brk_err_time", err_cyc_at(be), s + LAT);
    check("brk_no_en", n_en - b, 32'd0);
    check("brk_rout", {24'd0, rout}, 32'h30);
    idle(10);

    // Single-cycle inversion at the middle sample of data bit 3.
    b = n_en;
    send_frame(8'h77, 1'b1, 4 * BAUD_DIV + BAUD_DIV / 2 + 1, -1, s);
    idle(5);
    check("vote_count", n_en - b, 32'd1);
    check("vote_data", {24'd0, en_dat_at(b)}, 32'h77);
    check("vote_rout", {24'd0, rout}, 32'h77);

    // Reset during data bit 4, released while the line is still low.
    b = n_en; be = n_err;
    send_frame(8'h00, 1'b1, -1, 5 * BAUD_DIV + 2, s);
    idle(20);
    check("rst_no_en", n_en - b, 32'd0);
    check("rst_no_err", n_err - be, 32'd0);
    check("rst_rout", {24'd0, rout}, 32'h00);
    check("rst_idle_busy", {31'd0, rx_busy}, 32'd0);
    b = n_en;
    send_frame(8'h0d, 1'b1, -1, -1, s);
    idle(5);
    check("post_rst_count", n_en - b, 32'd1);
    check("post_rst_latency", en_cyc_at(b), s + LAT);
    check("post_rst_rout", {24'd0, rout}, 32'h0d);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
